// File: rtl/syscall_console_if.sv
// Syscall request, data-memory read port and console byte stream between the CPU and syscall_console_unit.
interface syscall_console_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic [31:0]       req_v0;
    logic [31:0]       req_a0;
    logic              busy;
    logic              done;
    logic              err;
    logic              halted;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;
    logic [31:0]       chars_printed;

    modport slave (
        input  req_valid, req_v0, req_a0, mem_rdata, char_ready,
        output busy, done, err, halted, mem_rd_en, mem_addr,
               char_valid, char_data, chars_printed
    );

    modport master (
        output req_valid, req_v0, req_a0, mem_rdata, char_ready,
        input  busy, done, err, halted, mem_rd_en, mem_addr,
               char_valid, char_data, chars_printed
    );
endinterface

// File: rtl/syscall_console_unit.sv
// Services print_char / print_hex / print_string / exit syscalls: stalls the pipeline,
// walks data memory for strings and streams ASCII bytes to a console sink.
module syscall_console_unit #(
    parameter int unsigned MAX_STR_LEN = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input logic              clk,
    input logic              reset,
    syscall_console_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(MAX_STR_LEN + 1);
    localparam logic [31:0] CODE_STR  = 32'd4;
    localparam logic [31:0] CODE_EXIT = 32'd10;
    localparam logic [31:0] CODE_CHAR = 32'd11;
    localparam logic [31:0] CODE_HEX  = 32'd34;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_HEX, S_DONE, S_HALT
    } state_t;

    state_t            state, state_n;
    logic              is_str, is_str_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [31:0]       word, word_n;
    logic [27:0]       hexval, hexval_n;
    logic [2:0]        nib_cnt, nib_cnt_n;
    logic              done, done_n;
    logic              err, err_n;
    logic              halted, halted_n;
    logic              mem_rd_en, mem_rd_en_n;
    logic [ADDR_W-1:0] mem_addr, mem_addr_n;
    logic              char_valid, char_valid_n;
    logic [7:0]        char_data, char_data_n;
    logic [31:0]       count, count_n;

    logic              hs;
    logic [ADDR_W-1:0] ptr_inc;
    logic [LEN_W-1:0]  len_inc;
    logic [7:0]        mem_byte;
    logic [7:0]        buf_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    assign hs       = char_valid && bus.char_ready;
    assign ptr_inc  = ptr + ADDR_W'(1);
    assign len_inc  = len + LEN_W'(1);
    assign mem_byte = bus.mem_rdata[{ptr[1:0], 3'b000} +: 8];
    assign buf_byte = word[{ptr_inc[1:0], 3'b000} +: 8];

    assign bus.busy = ((state != S_IDLE) && (state != S_HALT)) ||
                      ((state == S_IDLE) && bus.req_valid && !halted);
    assign bus.done          = done;
    assign bus.err           = err;
    assign bus.halted        = halted;
    assign bus.mem_rd_en     = mem_rd_en;
    assign bus.mem_addr      = mem_addr;
    assign bus.char_valid    = char_valid;
    assign bus.char_data     = char_data;
    assign bus.chars_printed = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            is_str     <= 1'b0;
            ptr        <= '0;
            len        <= '0;
            word       <= '0;
            hexval     <= '0;
            nib_cnt    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            halted     <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            char_valid <= 1'b0;
            char_data  <= '0;
            count      <= '0;
        end else begin
            state      <= state_n;
            is_str     <= is_str_n;
            ptr        <= ptr_n;
            len        <= len_n;
            word       <= word_n;
            hexval     <= hexval_n;
            nib_cnt    <= nib_cnt_n;
            done       <= done_n;
            err        <= err_n;
            halted     <= halted_n;
            mem_rd_en  <= mem_rd_en_n;
            mem_addr   <= mem_addr_n;
            char_valid <= char_valid_n;
            char_data  <= char_data_n;
            count      <= count_n;
        end
    end

    // Next-state and next register values; outputs are registered one state ahead.
    always_comb begin
        state_n      = state;
        is_str_n     = is_str;
        ptr_n        = ptr;
        len_n        = len;
        word_n       = word;
        hexval_n     = hexval;
        nib_cnt_n    = nib_cnt;
        done_n       = 1'b0;
        err_n        = err;
        halted_n     = halted;
        mem_rd_en_n  = 1'b0;
        mem_addr_n   = mem_addr;
        char_valid_n = char_valid;
        char_data_n  = char_data;
        count_n      = count;

        unique case (state)
            S_IDLE: begin
                if (bus.req_valid && !halted) begin
                    case (bus.req_v0)
                        CODE_CHAR: begin
                            state_n      = S_EMIT;
                            is_str_n     = 1'b0;
                            char_valid_n = 1'b1;
                            char_data_n  = bus.req_a0[7:0];
                        end
                        CODE_HEX: begin
                            state_n      = S_HEX;
                            hexval_n     = bus.req_a0[27:0];
                            nib_cnt_n    = '0;
                            char_valid_n = 1'b1;
                            char_data_n  = hex_ascii(bus.req_a0[31:28]);
                        end
                        CODE_STR: begin
                            state_n     = S_FETCH;
                            is_str_n    = 1'b1;
                            ptr_n       = ADDR_W'(bus.req_a0);
                            len_n       = '0;
                            mem_rd_en_n = 1'b1;
                            mem_addr_n  = {bus.req_a0[ADDR_W-1:2], 2'b00};
                        end
                        CODE_EXIT: begin
                            state_n  = S_HALT;
                            halted_n = 1'b1;
                            done_n   = 1'b1;
                        end
                        default: begin
                            state_n = S_DONE;
                            err_n   = 1'b1;
                            done_n  = 1'b1;
                        end
                    endcase
                end
            end
            S_FETCH: state_n = S_WAIT;
            S_WAIT: begin
                word_n = bus.mem_rdata;
                if ((mem_byte == 8'h00) || (len == LEN_W'(MAX_STR_LEN))) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n      = S_EMIT;
                    char_valid_n = 1'b1;
                    char_data_n  = mem_byte;
                end
            end
            S_EMIT: begin
                if (hs) begin
                    count_n      = count + 32'd1;
                    char_valid_n = 1'b0;
                    if (!is_str) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        ptr_n = ptr_inc;
                        len_n = len_inc;
                        // Crossing into the next word needs a memory read; otherwise reuse the buffer.
                        if (ptr_inc[1:0] == 2'b00) begin
                            state_n     = S_FETCH;
                            mem_rd_en_n = 1'b1;
                            mem_addr_n  = {ptr_inc[ADDR_W-1:2], 2'b00};
                        end else if ((buf_byte == 8'h00) || (len_inc == LEN_W'(MAX_STR_LEN))) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                        end else begin
                            char_valid_n = 1'b1;
                            char_data_n  = buf_byte;
                        end
                    end
                end
            end
            S_HEX: begin
                if (hs) begin
                    count_n = count + 32'd1;
                    if (nib_cnt == 3'd7) begin
                        state_n      = S_DONE;
                        char_valid_n = 1'b0;
                        done_n       = 1'b1;
                    end else begin
                        nib_cnt_n   = nib_cnt + 3'd1;
                        hexval_n    = {hexval[23:0], 4'h0};
                        char_data_n = hex_ascii(hexval[27:24]);
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end
endmodule
